// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin forced low, held high, or driven by a shared PWM
// waveform whose duty cycle is shadowed and only updated at period boundaries.
module pwm_peripheral #(
    parameter int PRESCALE   = 13,
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRESCALE_ONE  = PRESCALE_W'(1);
    localparam logic [7:0]            CNT_LAST      = 8'hFF;

    logic [PRESCALE_W-1:0] prescaler;
    logic [7:0]            pwm_cnt;
    logic [7:0]            duty_shadow;
    logic                  tick;
    logic                  wrap;
    logic                  pwm_level;
    logic [15:0]           en_out;
    logic [15:0]           en_pwm;
    logic [15:0]           out_next;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // With PRESCALE = 1 the compare value is 0, so tick stays high every cycle.
    assign tick = (prescaler == PRESCALE_LAST);
    assign wrap = tick && (pwm_cnt == CNT_LAST);

    // NOTE: every state register uses non-blocking assignments and is cleared by
    // the async reset, so out drops low the moment rst_n falls, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESCALE_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'h00;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // The shadow loads only on the 255 -> 0 wrap, so a mid-period write never cuts a pulse short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow  <= 8'h00;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (wrap) begin
                duty_shadow <= pwm_duty_cycle;
            end
        end
    end

    // 0xFF is special-cased so that full scale means high for all 256 ticks.
    assign pwm_level = (duty_shadow == CNT_LAST) || (pwm_cnt < duty_shadow);

    // NOTE: out_next is a pure function of its inputs with no hold path, so no latch can form.
    always_comb begin
        out_next = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 16'h0000;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (PRESCALE 13 and 1) with shared inputs, checked
// every cycle against a time-based reference model plus directed period measurements.
module tb_pwm_peripheral;

    localparam int P_A = 13;
    localparam int P_B = 1;
    localparam int PERIOD_A = 256 * P_A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out_a, out_b;
    logic        ps_a, ps_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(P_A), .PRESCALE_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out_a), .period_start(ps_a)
    );

    pwm_peripheral #(.PRESCALE(P_B), .PRESCALE_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out_b), .period_start(ps_b)
    );

    // Reference model: t counts clock edges since reset release. After t edges the
    // PWM counter equals floor(t/P) mod 256, and a new period begins whenever t is a
    // multiple of 256*P, at which point the requested duty is captured.
    int          t_a, t_b;
    logic [7:0]  sh_a, sh_b;
    logic [15:0] eo_a, eo_b;
    logic        ep_a, ep_b;

    function automatic logic [15:0] model_out(input int t, input int p, input logic [7:0] sh,
                                              input logic [15:0] eo, input logic [15:0] ep);
        int  cnt;
        logic lvl;
        cnt = (t / p) % 256;
        lvl = (sh == 8'hFF) || (cnt < int'(sh));
        return eo & (~ep | {16{lvl}});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_a <= 0; t_b <= 0; sh_a <= 8'h00; sh_b <= 8'h00;
            eo_a <= 16'h0000; eo_b <= 16'h0000; ep_a <= 1'b0; ep_b <= 1'b0;
        end else begin
            eo_a <= model_out(t_a, P_A, sh_a, en_out, en_pwm);
            eo_b <= model_out(t_b, P_B, sh_b, en_out, en_pwm);
            t_a  <= t_a + 1;
            t_b  <= t_b + 1;
            ep_a <= ((t_a + 1) % (256 * P_A)) == 0;
            ep_b <= ((t_b + 1) % (256 * P_B)) == 0;
            if (((t_a + 1) % (256 * P_A)) == 0) sh_a <= duty;
            if (((t_b + 1) % (256 * P_B)) == 0) sh_b <= duty;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge and compare both instances with the model.
    task automatic step();
        @(negedge clk);
        check("model_out_a", 32'(out_a), 32'(eo_a));
        check("model_ps_a",  32'(ps_a),  32'(ep_a));
        check("model_out_b", 32'(out_b), 32'(eo_b));
        check("model_ps_b",  32'(ps_b),  32'(ep_b));
    endtask

    // Wait (bounded) for period_start on instance a (sel=0) or b (sel=1), counting
    // cycles and the cycles in which pin 0 was high before the pulse.
    task automatic wait_ps(input bit sel, input int limit, output int cycles, output int highs);
        bit seen;
        seen = 1'b0; cycles = 0; highs = 0;
        while (cycles < limit) begin
            step();
            cycles++;
            if ((sel ? ps_b : ps_a) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            highs += int'(sel ? out_b[0] : out_a[0]);
        end
        check(sel ? "ps_b_timeout" : "ps_a_timeout", 32'(seen), 32'd1);
    endtask

    // Starting at a period_start sample, observe n samples of pin 0: high count and
    // number of separate high runs. Optionally change duty after sample set_at.
    task automatic measure(input bit sel, input int n, input int set_at, input logic [7:0] new_duty,
                           output int highs, output int runs);
        logic prev, cur;
        highs = 0; runs = 0; prev = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            cur = sel ? out_b[0] : out_a[0];
            highs += int'(cur);
            if (cur && !prev) runs++;
            prev = cur;
            if (k == set_at) duty = new_duty;
        end
    endtask

    int cyc, hi, runs;

    initial begin
        // 1: reset with every input high
        rst_n = 1'b0; en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'hFF;
        repeat (3) step();
        check("rst_out_a", 32'(out_a), 32'h0);
        check("rst_ps_a",  32'(ps_a),  32'h0);
        check("rst_out_b", 32'(out_b), 32'h0);
        rst_n = 1'b1;
        wait_ps(1'b0, PERIOD_A + 20, cyc, hi);
        check("first_ps_latency", 32'(cyc), 32'(PERIOD_A));
        check("pwm_low_before_first_ps", 32'(hi), 32'd0);
        step();
        check("full_duty_out_a", 32'(out_a), 32'hFFFF);

        // 2: static-high mode and a single enable drop
        en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h00;
        step();
        check("static_high", 32'(out_a), 32'hFFFF);
        en_out[3] = 1'b0;
        step();
        check("pin3_disabled", 32'(out_a), 32'hFFF7);
        repeat (300) step();

        // 3: prescale 1, pin 0 PWM at 0x40, 0x00, 0xFF
        en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h40;
        wait_ps(1'b1, 300, cyc, hi);
        check("p1_rise_not_at_ps", 32'(out_b[0]), 32'd0);
        measure(1'b1, 256, 0, 8'h00, hi, runs);
        check("p1_duty40_high", 32'(hi), 32'd64);
        check("p1_duty40_runs", 32'(runs), 32'd1);
        duty = 8'h00;
        wait_ps(1'b1, 300, cyc, hi);
        measure(1'b1, 256, 0, 8'h00, hi, runs);
        check("p1_duty00_high", 32'(hi), 32'd0);
        duty = 8'hFF;
        wait_ps(1'b1, 300, cyc, hi);
        measure(1'b1, 256, 0, 8'h00, hi, runs);
        check("p1_duty_ff_high", 32'(hi), 32'd256);

        // Randomized enables, modes and occasional duty writes against the model
        for (int i = 0; i < 4000; i++) begin
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
            if ($urandom_range(0, 15) == 0) duty = 8'($urandom);
            step();
        end

        // 4/5: mid-period duty change ignored, then a write coinciding with the wrap tick
        en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
        wait_ps(1'b0, PERIOD_A + 20, cyc, hi);
        measure(1'b0, PERIOD_A, 1300, 8'h20, hi, runs);
        check("p13_duty80_high", 32'(hi), 32'(128 * P_A));
        check("p13_duty80_runs", 32'(runs), 32'd1);
        check("p13_boundary1", 32'(ps_a), 32'd1);
        measure(1'b0, PERIOD_A, PERIOD_A - 1, 8'hC0, hi, runs);
        check("p13_duty20_high", 32'(hi), 32'(32 * P_A));
        check("p13_duty20_runs", 32'(runs), 32'd1);
        check("p13_boundary2", 32'(ps_a), 32'd1);
        measure(1'b0, 50, 0, 8'h00, hi, runs);
        check("wrap_write_applied", 32'(hi), 32'd50);

        // 6: async reset while pin 0 is high
        check("pre_reset_high", 32'(out_a[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_clear_out_a", 32'(out_a), 32'h0);
        check("async_clear_out_b", 32'(out_b), 32'h0);
        check("async_clear_ps_a",  32'(ps_a),  32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_ps(1'b0, PERIOD_A + 20, cyc, hi);
        check("restart_latency", 32'(cyc), 32'(PERIOD_A));
        check("restart_pwm_low", 32'(hi), 32'd0);
        step();
        check("restart_duty_loaded", 32'(out_a[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
